// File: rtl/tdd_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tdd_frame_ctrl
//
// Time-division-duplex frame sequencer. Once armed, each rising edge of the
// frame sync starts one frame made of three back-to-back windows:
// GUARD -> TX -> RX. At the start of TX a DMA start request is raised so the
// transmit data path can prefetch. A run is either a fixed number of frames,
// ending with a one-cycle done pulse, or continuous (num_frames = 0).
//
// Parameters
//   CNT_W       width of the window lengths and the window counter
//   FRM_W       width of num_frames and frame_cnt
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   sync_in      frame sync; only its rising edge is used
//   enable       level: 1 arms the controller, 0 aborts back to idle
//   guard_len    guard window length in cycles (0 behaves as 1)
//   tx_len       TX window length in cycles (0 behaves as 1)
//   rx_len       RX window length in cycles (0 behaves as 1)
//   num_frames   frames per run, 0 = continuous
//   dma_ack      DMA accepted the TX start request
//   tx_en        TX window active
//   rx_en        RX window active
//   dma_req      TX DMA start request
//   frame_cnt    completed frames in the current run (wraps)
//   busy         a frame is in progress (GUARD, TX or RX)
//   done         one-cycle pulse when a counted run completes
//   sync_overrun sticky: a sync edge arrived while a frame was in progress
//   dma_late     sticky: TX window ended before the DMA request was accepted
// -----------------------------------------------------------------------------
module tdd_frame_ctrl #(
  parameter int CNT_W = 16,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sync_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] guard_len,
  input  logic [CNT_W-1:0] tx_len,
  input  logic [CNT_W-1:0] rx_len,
  input  logic [FRM_W-1:0] num_frames,
  input  logic             dma_ack,
  output logic             tx_en,
  output logic             rx_en,
  output logic             dma_req,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             busy,
  output logic             done,
  output logic             sync_overrun,
  output logic             dma_late
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_GUARD = 3'd2,
    S_TX    = 3'd3,
    S_RX    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [FRM_W-1:0] FRM_ONE = 1;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q;
  logic             sync_edge;
  logic             cnt_zero;
  logic [FRM_W-1:0] frame_cnt_inc;
  logic             run_last;

  // Configuration captured at the sync edge so mid-frame input changes
  // cannot stretch or shorten a window already under way.
  logic [CNT_W-1:0] guard_len_q;
  logic [CNT_W-1:0] tx_len_q;
  logic [CNT_W-1:0] rx_len_q;
  logic [FRM_W-1:0] num_frames_q;

  // Counter reload value: a window of length N runs from N-1 down to 0,
  // and a zero length is treated as a one-cycle window.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - CNT_ONE);
  endfunction

  assign sync_edge     = sync_in & ~sync_q;
  assign cnt_zero      = (cnt == '0);
  assign frame_cnt_inc = frame_cnt + FRM_ONE;
  assign run_last      = (num_frames_q != '0) && (frame_cnt_inc == num_frames_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A low enable beats everything else in the armed and
  // window states, including a coincident sync edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would infer a latch.
    next_state = state;
    case (state)
      S_IDLE: begin
        if (enable) next_state = S_ARM;
      end
      S_ARM: begin
        if (!enable)        next_state = S_IDLE;
        else if (sync_edge) next_state = S_GUARD;
      end
      S_GUARD: begin
        if (!enable)       next_state = S_IDLE;
        else if (cnt_zero) next_state = S_TX;
      end
      S_TX: begin
        if (!enable)       next_state = S_IDLE;
        else if (cnt_zero) next_state = S_RX;
      end
      S_RX: begin
        if (!enable)       next_state = S_IDLE;
        else if (cnt_zero) next_state = run_last ? S_DONE : S_ARM;
      end
      S_DONE: begin
        if (!enable) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: window and busy flags come straight from the state
  // register, so they drop the instant reset asserts.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_en = (state == S_TX);
    rx_en = (state == S_RX);
    busy  = (state == S_GUARD) || (state == S_TX) || (state == S_RX);
  end

  // ---------------------------------------------------------------------------
  // Datapath: edge register, window counter, latched config, frame counter,
  // sticky flags and the one-cycle done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q       <= 1'b0;
      cnt          <= '0;
      guard_len_q  <= '0;
      tx_len_q     <= '0;
      rx_len_q     <= '0;
      num_frames_q <= '0;
      frame_cnt    <= '0;
      sync_overrun <= 1'b0;
      done         <= 1'b0;
    end else begin
      sync_q <= sync_in;
      done   <= (state != S_DONE) && (next_state == S_DONE);

      case (state)
        S_IDLE: begin
          // A new run starts with clean counters and error history; an
          // aborted run leaves them readable until then.
          if (enable) begin
            frame_cnt    <= '0;
            sync_overrun <= 1'b0;
          end
        end
        S_ARM: begin
          if (enable && sync_edge) begin
            guard_len_q  <= guard_len;
            tx_len_q     <= tx_len;
            rx_len_q     <= rx_len;
            num_frames_q <= num_frames;
            cnt          <= len_m1(guard_len);
          end
        end
        S_GUARD, S_TX, S_RX: begin
          if (enable) begin
            // A sync edge mid-frame is only reported; the frame keeps its
            // own timing.
            if (sync_edge) sync_overrun <= 1'b1;
            if (!cnt_zero) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              case (state)
                S_GUARD: cnt <= len_m1(tx_len_q);
                S_TX:    cnt <= len_m1(rx_len_q);
                default: begin
                  cnt       <= '0;
                  frame_cnt <= frame_cnt_inc;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // DMA handshake. The request is raised on entry to TX and cleared by the
  // first ack seen while it is high. If TX ends first the request is
  // withdrawn and flagged late, unless the ack lands on that very cycle.
  // An abort withdraws the request without flagging it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dma_req  <= 1'b0;
      dma_late <= 1'b0;
    end else begin
      if ((state == S_IDLE) && enable) begin
        dma_late <= 1'b0;
      end
      if ((state == S_GUARD) && (next_state == S_TX)) begin
        dma_req <= 1'b1;
      end else if ((state == S_TX) && (next_state != S_TX)) begin
        if (enable && dma_req && !dma_ack) dma_late <= 1'b1;
        dma_req <= 1'b0;
      end else if (dma_req && dma_ack) begin
        dma_req <= 1'b0;
      end
    end
  end

endmodule
